// File: rtl/onewire_pkg.sv
// Shared encodings and slot/reset timing constants for the 1-Wire master sequencer.
// All tick constants are in bus ticks (1 us normal speed, ~1/8 us overdrive).
package onewire_pkg;

  typedef enum logic [1:0] {
    CMD_RST  = 2'b00,
    CMD_BIT  = 2'b01,
    CMD_BYTE = 2'b10,
    CMD_RSV  = 2'b11
  } cmd_typ_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_LOW  = 3'd1,
    S_RST_WAIT = 3'd2,
    S_SLOT_LOW = 3'd3,
    S_SLOT_REL = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam logic [9:0] T_RSTL = 10'd480;
  localparam logic [9:0] T_PDS  = 10'd550;
  localparam logic [9:0] T_RST  = 10'd960;
  localparam logic [9:0] T_W1L  = 10'd6;
  localparam logic [9:0] T_W0L  = 10'd60;
  localparam logic [9:0] T_RDS  = 10'd12;
  localparam logic [9:0] T_SLOT = 10'd64;

endpackage

// File: rtl/onewire_clk_div.sv
// Bus tick generator: one-cycle tick every CDR_N (normal) or CDR_O (overdrive) clocks.
// clr restarts the count so the first tick lands exactly one tick period later.
module onewire_clk_div #(
  parameter int unsigned CDR_N = 50,
  parameter int unsigned CDR_O = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ovd,
  output logic tick
);

  localparam int unsigned CDR_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
  localparam int unsigned W       = (CDR_MAX > 1) ? $clog2(CDR_MAX) : 1;
  localparam logic [W-1:0] LAST_N = W'(CDR_N - 1);
  localparam logic [W-1:0] LAST_O = W'(CDR_O - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == (ovd ? LAST_O : LAST_N));

  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/onewire_master_seq.sv
// 1-Wire bus master sequencer: reset/presence, single-bit and byte slots over a
// valid/ready command interface, driving the open-drain line through owr_e.
module onewire_master_seq
  import onewire_pkg::*;
#(
  parameter int unsigned CDR_N   = 50,
  parameter int unsigned CDR_O   = 6,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [1:0] cmd_typ,
  input  logic       cmd_ovd,
  input  logic [7:0] cmd_dat,
  output logic       rsp_vld,
  output logic [7:0] rsp_dat,
  output logic       rsp_pdt,
  output logic       busy,
  output logic       owr_e,
  input  logic       owr_i
);

  state_e     state;
  cmd_typ_e   typ;
  logic       ovd;
  logic [7:0] shreg;
  logic       wbit;
  logic [9:0] tcnt;
  logic [2:0] bcnt;
  logic       tick;
  logic       line_s;
  logic       accept;

  assign cmd_rdy = (state == S_IDLE);
  assign busy    = (state != S_IDLE);
  assign accept  = cmd_vld && cmd_rdy;

  generate
    if (SYNC_EN) begin : g_sync
      logic [1:0] sync;
      always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], owr_i};
      end
      assign line_s = sync[1];
    end else begin : g_nosync
      assign line_s = owr_i;
    end
  endgenerate

  onewire_clk_div #(
    .CDR_N (CDR_N),
    .CDR_O (CDR_O)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .ovd  (ovd),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      typ     <= CMD_RST;
      ovd     <= 1'b0;
      shreg   <= '0;
      wbit    <= 1'b0;
      tcnt    <= '0;
      bcnt    <= '0;
      owr_e   <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_dat <= '0;
      rsp_pdt <= 1'b0;
    end else begin
      rsp_vld <= 1'b0;
      if (tick && state != S_IDLE && state != S_DONE) tcnt <= tcnt + 10'd1;
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            typ     <= cmd_typ_e'(cmd_typ);
            ovd     <= cmd_ovd && (cmd_typ_e'(cmd_typ) != CMD_RST);
            shreg   <= cmd_dat;
            wbit    <= cmd_dat[0];
            tcnt    <= '0;
            bcnt    <= '0;
            rsp_dat <= '0;
            rsp_pdt <= 1'b0;
            case (cmd_typ_e'(cmd_typ))
              CMD_RST: begin
                state <= S_RST_LOW;
                owr_e <= 1'b1;
              end
              CMD_BIT, CMD_BYTE: begin
                state <= S_SLOT_LOW;
                owr_e <= 1'b1;
              end
              default: begin
                state   <= S_DONE;
                rsp_vld <= 1'b1;
              end
            endcase
          end
        end
        S_RST_LOW: begin
          if (tick && tcnt == T_RSTL - 10'd1) begin
            owr_e <= 1'b0;
            state <= S_RST_WAIT;
          end
        end
        S_RST_WAIT: begin
          if (tick) begin
            if (tcnt == T_PDS - 10'd1) rsp_pdt <= ~line_s;
            if (tcnt == T_RST - 10'd1) begin
              state   <= S_DONE;
              rsp_vld <= 1'b1;
            end
          end
        end
        S_SLOT_LOW, S_SLOT_REL: begin
          if (tick) begin
            if (state == S_SLOT_LOW && tcnt == (wbit ? T_W1L : T_W0L) - 10'd1) begin
              owr_e <= 1'b0;
              state <= S_SLOT_REL;
            end
            // Shift happens mid-slot, so shreg[0] already holds the next write bit at slot end.
            if (tcnt == T_RDS - 10'd1) shreg <= {line_s, shreg[7:1]};
            if (tcnt == T_SLOT - 10'd1) begin
              if (typ == CMD_BYTE && bcnt != 3'd7) begin
                bcnt  <= bcnt + 3'd1;
                tcnt  <= '0;
                wbit  <= shreg[0];
                owr_e <= 1'b1;
                state <= S_SLOT_LOW;
              end else begin
                state   <= S_DONE;
                rsp_vld <= 1'b1;
                rsp_dat <= (typ == CMD_BIT) ? {7'b0, shreg[7]} : shreg;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_master_seq.sv
// Directed bench for onewire_master_seq with CDR_N=4, CDR_O=1 and a simple slave model
// that pulls the line low for presence or for read-0 slots.
module tb_onewire_master_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [1:0] cmd_typ;
  logic       cmd_ovd;
  logic [7:0] cmd_dat;
  logic       rsp_vld;
  logic [7:0] rsp_dat;
  logic       rsp_pdt;
  logic       busy;
  logic       owr_e;
  logic       owr_i;

  int checks = 0;
  int errors = 0;

  // slave model: 0 none, 1 presence after reset low, 2 return slave_bits on slots
  int         slave_mode = 0;
  logic [7:0] slave_bits = 8'h00;
  int         slave_idx  = 0;
  int         hold       = 0;
  logic       prev_e     = 1'b0;

  // captured by run_cmd
  int         pw[16];
  int         pr[16];
  int         npulse;
  bit         got_rsp;
  int         rsp_cyc;
  logic [7:0] rsp_d;
  logic       rsp_p;
  int         nbusy_lo;
  int         nrdy_hi;

  always #5 clk = ~clk;

  onewire_master_seq #(
    .CDR_N   (4),
    .CDR_O   (1),
    .SYNC_EN (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_typ (cmd_typ),
    .cmd_ovd (cmd_ovd),
    .cmd_dat (cmd_dat),
    .rsp_vld (rsp_vld),
    .rsp_dat (rsp_dat),
    .rsp_pdt (rsp_pdt),
    .busy    (busy),
    .owr_e   (owr_e),
    .owr_i   (owr_i)
  );

  assign owr_i = (hold == 0);

  always @(posedge clk) begin
    prev_e <= owr_e;
    if (hold > 0) hold <= hold - 1;
    if (slave_mode == 1 && prev_e && !owr_e) hold <= 800;
    if (slave_mode == 2 && !prev_e && owr_e) begin
      if (slave_bits[slave_idx[2:0]] == 1'b0) hold <= 30;
      slave_idx <= slave_idx + 1;
    end
  end

  task automatic run_cmd(input logic [1:0] typ, input logic ov, input logic [7:0] dat,
                         input bit keep_vld, input int maxcyc);
    int hi;
    @(negedge clk);
    cmd_typ = typ; cmd_ovd = ov; cmd_dat = dat; cmd_vld = 1'b1;
    @(negedge clk);
    if (!keep_vld) cmd_vld = 1'b0;
    npulse = 0; got_rsp = 0; rsp_cyc = -1; nbusy_lo = 0; nrdy_hi = 0; hi = 0;
    for (int t = 0; t < maxcyc; t++) begin
      if (owr_e) begin
        if (hi == 0 && npulse < 16) pr[npulse] = t;
        hi++;
      end else if (hi > 0) begin
        if (npulse < 16) pw[npulse] = hi;
        npulse++;
        hi = 0;
      end
      if (!busy) nbusy_lo++;
      if (cmd_rdy) nrdy_hi++;
      if (rsp_vld) begin
        got_rsp = 1; rsp_cyc = t; rsp_d = rsp_dat; rsp_p = rsp_pdt;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_vld = 1'b0; cmd_typ = 2'b00; cmd_ovd = 1'b0; cmd_dat = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (owr_e !== 1'b0)   begin errors++; $display("FAIL reset_owr_e: got %b exp 0", owr_e); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy: got %b exp 1", cmd_rdy); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %b exp 0", rsp_vld); end
    checks++; if (rsp_dat !== 8'h00) begin errors++; $display("FAIL reset_rsp_dat: got %h exp 00", rsp_dat); end
    checks++; if (rsp_pdt !== 1'b0) begin errors++; $display("FAIL reset_rsp_pdt: got %b exp 0", rsp_pdt); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
  endtask

  task automatic test_byte_write;
    int exp_w[8] = '{24, 240, 24, 240, 240, 24, 240, 24};
    slave_mode = 0;
    run_cmd(2'b10, 1'b0, 8'hA5, 1'b0, 3000);
    checks++; if (!got_rsp || rsp_cyc != 2048) begin errors++; $display("FAIL wr_rsp_cycle: got %0d exp 2048", rsp_cyc); end
    checks++; if (npulse != 8) begin errors++; $display("FAIL wr_npulse: got %0d exp 8", npulse); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (pw[i] != exp_w[i]) begin errors++; $display("FAIL wr_width[%0d]: got %0d exp %0d", i, pw[i], exp_w[i]); end
      checks++; if (pr[i] != 256 * i) begin errors++; $display("FAIL wr_start[%0d]: got %0d exp %0d", i, pr[i], 256 * i); end
    end
    checks++; if (rsp_d !== 8'hFF) begin errors++; $display("FAIL wr_rsp_dat: got %h exp ff", rsp_d); end
    checks++; if (nbusy_lo != 0) begin errors++; $display("FAIL wr_busy: got %0d idle cycles exp 0", nbusy_lo); end
  endtask

  task automatic test_rst_presence;
    slave_mode = 1;
    run_cmd(2'b00, 1'b1, 8'h5A, 1'b0, 5000);
    checks++; if (npulse != 1 || pr[0] != 0 || pw[0] != 1920) begin errors++; $display("FAIL rstp_low: got n=%0d start=%0d len=%0d exp 1/0/1920", npulse, pr[0], pw[0]); end
    checks++; if (!got_rsp || rsp_cyc != 3840) begin errors++; $display("FAIL rstp_rsp_cycle: got %0d exp 3840", rsp_cyc); end
    checks++; if (rsp_p !== 1'b1) begin errors++; $display("FAIL rstp_pdt: got %b exp 1", rsp_p); end
    checks++; if (rsp_d !== 8'h00) begin errors++; $display("FAIL rstp_dat: got %h exp 00", rsp_d); end
    @(negedge clk);
    checks++; if (rsp_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstp_after: got vld=%b busy=%b exp 0/0", rsp_vld, busy); end
    checks++; if (rsp_pdt !== 1'b1) begin errors++; $display("FAIL rstp_pdt_hold: got %b exp 1", rsp_pdt); end
  endtask

  task automatic test_rst_noslave;
    slave_mode = 0;
    run_cmd(2'b00, 1'b0, 8'h00, 1'b0, 5000);
    checks++; if (npulse != 1 || pw[0] != 1920) begin errors++; $display("FAIL rstn_low: got n=%0d len=%0d exp 1/1920", npulse, pw[0]); end
    checks++; if (!got_rsp || rsp_cyc != 3840) begin errors++; $display("FAIL rstn_rsp_cycle: got %0d exp 3840", rsp_cyc); end
    checks++; if (rsp_p !== 1'b0) begin errors++; $display("FAIL rstn_pdt: got %b exp 0", rsp_p); end
    checks++; if (rsp_d !== 8'h00) begin errors++; $display("FAIL rstn_dat: got %h exp 00", rsp_d); end
  endtask

  task automatic test_byte_read_ovd;
    slave_mode = 2; slave_bits = 8'h3C; slave_idx = 0;
    run_cmd(2'b10, 1'b1, 8'hFF, 1'b0, 1000);
    checks++; if (!got_rsp || rsp_cyc != 512) begin errors++; $display("FAIL rd_rsp_cycle: got %0d exp 512", rsp_cyc); end
    checks++; if (npulse != 8) begin errors++; $display("FAIL rd_npulse: got %0d exp 8", npulse); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (pw[i] != 6 || pr[i] != 64 * i) begin errors++; $display("FAIL rd_slot[%0d]: got len=%0d start=%0d exp 6/%0d", i, pw[i], pr[i], 64 * i); end
    end
    checks++; if (rsp_d !== 8'h3C) begin errors++; $display("FAIL rd_rsp_dat: got %h exp 3c", rsp_d); end
    slave_mode = 0;
  endtask

  task automatic test_rst_mid;
    slave_mode = 0;
    @(negedge clk);
    cmd_typ = 2'b00; cmd_ovd = 1'b0; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (owr_e !== 1'b1) begin errors++; $display("FAIL mid_low_before: got %b exp 1", owr_e); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (owr_e !== 1'b0)   begin errors++; $display("FAIL mid_owr_e: got %b exp 0", owr_e); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL mid_cmd_rdy: got %b exp 1", cmd_rdy); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL mid_rsp_vld: got %b exp 0", rsp_vld); end
    run_cmd(2'b01, 1'b0, 8'h01, 1'b0, 400);
    checks++; if (!got_rsp || rsp_cyc != 256) begin errors++; $display("FAIL mid_bit_cycle: got %0d exp 256", rsp_cyc); end
    checks++; if (npulse != 1 || pw[0] != 24) begin errors++; $display("FAIL mid_bit_pulse: got n=%0d len=%0d exp 1/24", npulse, pw[0]); end
    checks++; if (rsp_d !== 8'h01) begin errors++; $display("FAIL mid_bit_dat: got %h exp 01", rsp_d); end
  endtask

  task automatic test_back_to_back;
    slave_mode = 0;
    run_cmd(2'b10, 1'b1, 8'hFF, 1'b1, 1000);
    checks++; if (!got_rsp || rsp_cyc != 512) begin errors++; $display("FAIL b2b_rsp_cycle: got %0d exp 512", rsp_cyc); end
    checks++; if (nrdy_hi != 0) begin errors++; $display("FAIL b2b_rdy_busy: got %0d ready cycles exp 0", nrdy_hi); end
    checks++; if (rsp_d !== 8'hFF) begin errors++; $display("FAIL b2b_dat: got %h exp ff", rsp_d); end
    cmd_typ = 2'b11;
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got rdy=%b busy=%b exp 1/0", cmd_rdy, busy); end
    @(negedge clk);
    cmd_vld = 1'b0;
    checks++; if (rsp_vld !== 1'b1 || busy !== 1'b1 || owr_e !== 1'b0) begin errors++; $display("FAIL b2b_rsv_done: got vld=%b busy=%b e=%b exp 1/1/0", rsp_vld, busy, owr_e); end
    checks++; if (rsp_dat !== 8'h00 || rsp_pdt !== 1'b0) begin errors++; $display("FAIL b2b_rsv_rsp: got %h/%b exp 00/0", rsp_dat, rsp_pdt); end
    @(negedge clk);
    checks++; if (rsp_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_rsv_after: got vld=%b busy=%b exp 0/0", rsp_vld, busy); end
  endtask

  task automatic test_reserved;
    run_cmd(2'b11, 1'b0, 8'hC3, 1'b0, 20);
    checks++; if (!got_rsp || rsp_cyc != 0) begin errors++; $display("FAIL rsv_cycle: got %0d exp 0", rsp_cyc); end
    checks++; if (npulse != 0 || owr_e !== 1'b0) begin errors++; $display("FAIL rsv_owr_e: got %0d pulses exp 0", npulse); end
    checks++; if (rsp_d !== 8'h00 || rsp_p !== 1'b0) begin errors++; $display("FAIL rsv_rsp: got %h/%b exp 00/0", rsp_d, rsp_p); end
  endtask

  initial begin
    test_reset;
    test_byte_write;
    test_rst_presence;
    test_rst_noslave;
    test_byte_read_ovd;
    test_rst_mid;
    test_back_to_back;
    test_reserved;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
